// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: IMEM fetch port, redirect request and decode-side valid/ready bundle.
interface ifetch_queue_if;
    logic [31:0] Instr_Addr;
    logic [31:0] Instr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    modport master (
        output Instr_Addr, out_valid, out_pc, out_instr,
        input  Instr_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  Instr_Addr, out_valid, out_pc, out_instr,
        output Instr_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, drives IMEM and buffers {pc, instr} pairs for decode.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic            clk,
    input logic            reset_n,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic          out_valid, enq, deq;
    logic          unused_low_bits;
    assign unused_low_bits = ^bus.redirect_pc[1:0];
    always_comb begin
        out_valid = count_q != '0;
        deq = out_valid & bus.out_ready;
        enq = !bus.redirect_valid & ((count_q < CW'(DEPTH)) | deq);
        pc_d = pc_q;
        instr_d = instr_q;
        if (enq) begin
            pc_d[wr_ptr_q] = fetch_pc_q;
            instr_d[wr_ptr_q] = bus.Instr_rdata;
        end
        // Redirect flushes everything and silently word-aligns the target.
        fetch_pc_d = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00}
                   : enq ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rd_ptr_d = bus.redirect_valid ? '0 : rd_ptr_q + AW'(deq);
        wr_ptr_d = bus.redirect_valid ? '0 : wr_ptr_q + AW'(enq);
        count_d  = bus.redirect_valid ? '0 : count_q + CW'(enq) - CW'(deq);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_q       <= '{default: '0};
            instr_q    <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end
    assign bus.Instr_Addr = fetch_pc_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = pc_q[rd_ptr_q];
    assign bus.out_instr  = instr_q[rd_ptr_q];
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus random traffic checked against a queue-based fetch model.
module tb_ifetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic [31:0] words [4] = '{32'h123450B7, 32'hFFFFF137, 32'h00001197, 32'hABCDE217};
    ifetch_queue_if bus();
    ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a < 32'h10 && a[1:0] == 2'b00) return words[a[3:2]];
        return (a * 32'h9E3779B1) ^ 32'h0001_3579;
    endfunction
    assign bus.Instr_rdata = imem(bus.Instr_Addr);
    task automatic tick();
        bit d;
        int n;
        @(posedge clk);
        if (reset_n) begin
            n = mq.size();
            d = n != 0 && bus.out_ready;
            if (bus.redirect_valid) begin
                mq.delete();
                mpc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (d) void'(mq.pop_front());
                if (n < DEPTH || d) begin
                    mq.push_back({mpc, imem(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask
    task automatic apply_reset();
        bus.redirect_valid = 1'b0;
        reset_n = 1'b0;
        mq.delete();
        mpc = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    task automatic test_reset();
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        #1 reset_n = 1'b0;
        mq.delete();
        mpc = RESET_PC;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.out_instr); end
        checks++; if (bus.Instr_Addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", bus.Instr_Addr, RESET_PC); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    task automatic test_streaming();
        bus.out_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_pc, 32'(i * 4)); end
            checks++; if (bus.out_instr !== words[i]) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, bus.out_instr, words[i]); end
        end
    endtask
    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) begin
                checks++; if (bus.Instr_Addr !== 32'h8) begin errors++; $display("FAIL bp_addr[%0d] got %h want 00000008", i, bus.Instr_Addr); end
                checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== words[0]) begin errors++; $display("FAIL bp_hold[%0d] got %h/%h want 00000000/%h", i, bus.out_pc, bus.out_instr, words[0]); end
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.out_instr !== words[i]) begin errors++; $display("FAIL bp_drain[%0d] got v=%b %h/%h want v=1 %h/%h", i, bus.out_valid, bus.out_pc, bus.out_instr, 32'(i * 4), words[i]); end
            tick();
        end
    endtask
    task automatic test_redirect_stream();
        bus.out_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        checks++; if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL rs_pre got %h want 00000004", bus.out_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000000B;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.Instr_Addr !== 32'h8 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rs_flush got addr=%h v=%b want addr=00000008 v=0", bus.Instr_Addr, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8 || bus.out_instr !== 32'h00001197) begin errors++; $display("FAIL rs_target got v=%b %h/%h want v=1 00000008/00001197", bus.out_valid, bus.out_pc, bus.out_instr); end
        tick();
        checks++; if (bus.out_pc !== 32'hC) begin errors++; $display("FAIL rs_next got %h want 0000000c", bus.out_pc); end
    endtask
    task automatic test_redirect_full();
        bus.out_ready = 1'b0;
        apply_reset();
        tick();
        tick();
        checks++; if (bus.out_pc !== 32'h0 || bus.Instr_Addr !== 32'h8) begin errors++; $display("FAIL rf_full got pc=%h addr=%h want 00000000/00000008", bus.out_pc, bus.Instr_Addr); end
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hC;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin errors++; $display("FAIL rf_deliver got v=%b %h want v=1 00000000", bus.out_valid, bus.out_pc); end
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.Instr_Addr !== 32'hC) begin errors++; $display("FAIL rf_flush got v=%b addr=%h want v=0 0000000c", bus.out_valid, bus.Instr_Addr); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hC || bus.out_instr !== 32'hABCDE217) begin errors++; $display("FAIL rf_target got v=%b %h/%h want v=1 0000000c/abcde217", bus.out_valid, bus.out_pc, bus.out_instr); end
    endtask
    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got v=%b want 1", bus.out_valid); end
        #2 reset_n = 1'b0;
        mq.delete();
        mpc = RESET_PC;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL ar_clear got v=%b %h/%h want v=0 0/0", bus.out_valid, bus.out_pc, bus.out_instr); end
        checks++; if (bus.Instr_Addr !== RESET_PC) begin errors++; $display("FAIL ar_addr got %h want %h", bus.Instr_Addr, RESET_PC); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC || bus.out_instr !== words[0]) begin errors++; $display("FAIL ar_restart got v=%b %h/%h want v=1 %h/%h", bus.out_valid, bus.out_pc, bus.out_instr, RESET_PC, words[0]); end
        tick();
        checks++; if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL ar_next got %h want 00000004", bus.out_pc); end
    endtask
    task automatic test_wrap();
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFFFFFC;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.Instr_Addr !== 32'hFFFFFFFC || bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush got addr=%h v=%b want fffffffc v=0", bus.Instr_Addr, bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFFFFFC + 32'(i * 4)) begin errors++; $display("FAIL wrap_pc[%0d] got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_pc, 32'hFFFFFFFC + 32'(i * 4)); end
            checks++; if (bus.Instr_Addr !== 32'(i * 4)) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, bus.Instr_Addr, 32'(i * 4)); end
        end
    endtask
    task automatic test_random();
        bus.out_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            checks++; if (bus.out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.out_valid, mq.size() != 0); end
            checks++; if (bus.Instr_Addr !== mpc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, bus.Instr_Addr, mpc); end
            if (mq.size() != 0) begin
                checks++; if ({bus.out_pc, bus.out_instr} !== mq[0]) begin errors++; $display("FAIL rnd_head[%0d] got %h/%h want %h/%h", i, bus.out_pc, bus.out_instr, mq[0][63:32], mq[0][31:0]); end
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.redirect_valid = $urandom_range(0, 15) == 0;
            bus.redirect_pc = $urandom;
            tick();
        end
        bus.redirect_valid = 1'b0;
    endtask
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_stream();
        test_redirect_full();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the combinational instruction memory.
- Owns the fetch PC and drives the IMEM address.
- Captures the returned instruction word with its PC into a small prefetch queue.
- Presents {pc, instr} to decode over a valid/ready handshake; supports backpressure and redirect (branch/jump) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, queue entries; power of 2, minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Instr_Addr  output  32  byte address to IMEM; equals the fetch_pc register.
- Instr_rdata  input  32  instruction word from IMEM; combinational, valid in the same cycle as Instr_Addr.
- redirect_valid  input  1  load a new fetch PC and flush the queue.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction word of the head entry.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - fetch_pc = RESET_PC, so Instr_Addr = RESET_PC.
  - count = 0, read and write pointers = 0.
  - All queue storage = 0, so out_valid = 0, out_pc = 0, out_instr = 0.
  - Reset asserted mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
- Handshake:
  - deq = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_pc and out_instr come from the head entry.
  - While out_valid=1 and out_ready=0, out_pc and out_instr hold stable; only redirect or reset may change them.
- Enqueue:
  - enq = !redirect_valid & ((count < DEPTH) | deq).
  - On enq, write {fetch_pc, Instr_rdata} at the write pointer and set fetch_pc <= fetch_pc + 4.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Full, no dequeue: fetch_pc holds, so Instr_Addr is stable; no write.
- Full with dequeue in the same cycle: enqueue and dequeue both occur; count is unchanged.
- Empty: out_valid=0; out_ready is ignored.
- Count update:
  - count_next = count + enq - deq.
  - Pointers advance modulo DEPTH.
  - count never exceeds DEPTH and never underflows.
- Redirect (highest priority):
  - In cycle N with redirect_valid=1, a handshake (deq) in cycle N counts as delivered to decode.
  - At the edge ending cycle N: all remaining entries are discarded (count=0, pointers=0), nothing is enqueued, and fetch_pc <= {redirect_pc[31:2], 2'b00}. Misaligned targets are silently aligned.
  - Cycle N+1: Instr_Addr = target, out_valid = 0.
  - Cycle N+2: out_valid = 1, out_pc = target.
  - Back-to-back redirects: the last one wins; each one flushes.
- Latency and throughput:
  - After reset release, the first rising edge enqueues RESET_PC; out_valid=1 from that edge.
  - With out_ready held at 1: one instruction per cycle, out_pc increments by 4 each cycle, no bubbles.
- IMEM address range and decoding belong to IMEM; this block never checks bounds.
- No combinational path from out_ready or redirect_* to Instr_Addr or out_valid; both are register outputs.

Test Plan:
1. Streaming: IMEM words 0x123450B7, 0xFFFFF137, 0x00001197, 0xABCDE217 at addresses 0x0/0x4/0x8/0xC; release reset with out_ready=1. Required: (out_pc, out_instr) = (0x0, 0x123450B7), (0x4, 0xFFFFF137), (0x8, 0x00001197), (0xC, 0xABCDE217) on four consecutive cycles after the first edge.
2. Backpressure: out_ready=0 from reset for 10 cycles. Required: after 2 edges count=2, Instr_Addr holds 0x8, out_pc=0x0 / out_instr=0x123450B7 stable. Then raise out_ready. Required: 0x0, 0x4, 0x8, 0xC delivered with no gap, no duplicate, no skip.
3. Redirect while streaming: assert redirect_valid=1 with redirect_pc=0x0000000B at a cycle where out_pc=0x4. Required: next cycle Instr_Addr=0x8 and out_valid=0; following cycle out_pc=0x8, out_instr=0x00001197; no stale entry from the old stream.
4. Redirect with full queue: queue full (heads 0x0, 0x4), out_ready=1, redirect to 0xC in the same cycle. Required: 0x0 is delivered; 0x4 never appears; the next valid entry is out_pc=0xC, out_instr=0xABCDE217.
5. Asynchronous reset mid-stream: drive reset_n low between clock edges while out_valid=1. Required: out_valid=0, out_pc=0, out_instr=0, Instr_Addr=RESET_PC immediately, without waiting for an edge. On release, the stream restarts at RESET_PC.
6. Wrap-around: redirect to 0xFFFFFFFC with out_ready=1. Required: out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004 on consecutive cycles; Instr_Addr wraps identically.
